// File: rtl/cp0.sv
// rtl/cp0.sv - coprocessor 0: SR/Cause/EPC/PRId, interrupt request and eret handling
module cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        eret,
    input  logic [5:0]  hwint,
    output logic        intreq,
    output logic [31:0] epc,
    output logic [31:0] dout
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h2024_0001;

    // Only the architecturally meaningful fields are stored; unused bits read as 0.
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [29:0] epc_q, epc_d;

    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;
    logic [31:0] pc_plus4;
    logic        wr_sr;
    logic        wr_epc;

    assign sr_val    = {16'h0, im_q, 8'h0, exl_q, ie_q};
    assign cause_val = {16'h0, ip_q, 3'b000, exc_code_q, 2'b00};
    assign epc_val   = {epc_q, 2'b00};
    assign pc_plus4  = pc + 32'd4;
    assign wr_sr     = we && (a2 == REG_SR);
    assign wr_epc    = we && (a2 == REG_EPC);

    // Interrupt request: purely combinational from live hwint and the registered SR.
    always_comb begin
        intreq = (|(hwint & im_q)) & ie_q & ~exl_q;
    end

    // mfc0 read mux; shows the pre-write value when the same register is written.
    always_comb begin
        dout = 32'h0;
        case (a1)
            REG_SR:    dout = sr_val;
            REG_CAUSE: dout = cause_val;
            REG_EPC:   dout = epc_val;
            REG_PRID:  dout = PRID_VAL;
            default:   dout = 32'h0;
        endcase
    end

    assign epc = epc_val;

    // Next-state: mtc0 applied first, then eret, then interrupt entry, so later
    // assignments override earlier ones for the fields they touch.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_d       = hwint;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (wr_sr) begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
        end
        if (wr_epc) begin
            epc_d = din[31:2];
        end
        if (eret) begin
            exl_d = 1'b0;
        end
        if (intreq) begin
            exl_d      = 1'b1;
            exc_code_d = 5'd0;
            epc_d      = pc_plus4[31:2];
        end
    end

    // State registers with synchronous reset dominating every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_q       <= 6'h0;
            exc_code_q <= 5'h0;
            epc_q      <= 30'h0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

endmodule
